// File: rtl/l2_bank_port_arbiter.sv
// Two-master round-robin front end for the L2 bank: drives the active-low SRAM
// pins and returns one response per grant, one cycle later.
module l2_bank_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 29184,
    parameter logic [31:0] ERR_DATA   = 32'hBADACCE5
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [1:0]                          req_i,
    input  logic [1:0][ADDR_WIDTH+1:0]          add_i,
    input  logic [1:0]                          wen_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]        be_i,
    input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
    output logic [1:0]                          gnt_o,
    output logic [1:0]                          rvalid_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                rerr_o,
    output logic                                CEN,
    output logic                                WEN,
    output logic [DATA_WIDTH/8-1:0]             BEN,
    output logic [ADDR_WIDTH-1:0]               A,
    output logic [DATA_WIDTH-1:0]               D,
    input  logic [DATA_WIDTH-1:0]               Q
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic valid;
        logic port;
        logic read;
        logic err;
    } resp_t;

    localparam resp_t RESP_RESET = '{valid: 1'b0, port: 1'b0, read: 1'b1, err: 1'b0};

    logic                  rr_q, rr_d;
    resp_t                 resp_q, resp_d;
    logic                  win;
    logic                  grant;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  resp_live;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{add_i[0][1:0], add_i[1][1:0]};

    // Winner selection: a lone requester wins, otherwise the rr pointer decides.
    always_comb begin
        grant = (|req_i) && !RST;
        win   = rr_q;
        if (req_i == 2'b01) begin
            win = 1'b0;
        end else if (req_i == 2'b10) begin
            win = 1'b1;
        end
        word_addr = add_i[win][ADDR_WIDTH+1:2];
        in_range  = 32'(word_addr) < MEM_WORDS;
    end

    // Bank pins idle high/zero unless a grant is issued this cycle.
    always_comb begin
        gnt_o = '0;
        CEN   = 1'b1;
        WEN   = 1'b1;
        BEN   = '1;
        A     = '0;
        D     = '0;
        if (grant) begin
            gnt_o[win] = 1'b1;
            A          = word_addr;
            D          = wdata_i[win];
            WEN        = wen_i[win];
            BEN        = ~be_i[win];
            CEN        = ~in_range;
        end
    end

    always_comb begin
        rr_d         = rr_q;
        resp_d       = resp_q;
        resp_d.valid = 1'b0;
        if (grant) begin
            rr_d   = ~win;
            resp_d = '{valid: 1'b1, port: win, read: wen_i[win], err: ~in_range};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q   <= 1'b0;
            resp_q <= RESP_RESET;
        end else begin
            rr_q   <= rr_d;
            resp_q <= resp_d;
        end
    end

    // A response still pending while reset is high is suppressed.
    always_comb begin
        resp_live = resp_q.valid && !RST;
        rvalid_o  = '0;
        rerr_o    = 1'b0;
        rdata_o   = '0;
        if (resp_live) begin
            rvalid_o[resp_q.port] = 1'b1;
            rerr_o                = resp_q.err;
            if (resp_q.read) begin
                rdata_o = resp_q.err ? DATA_WIDTH'(ERR_DATA) : Q;
            end
        end
    end

    logic [BE_WIDTH-1:0] unused_be_width;
    assign unused_be_width = '0;

endmodule

// File: tb/tb_l2_bank_port_arbiter.sv
// Bench for l2_bank_port_arbiter: per-cycle vector table with a response
// scoreboard and a behavioural SRAM model behind the bank pins.
module tb_l2_bank_port_arbiter;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [1:0]        req_i = '0;
    logic [1:0][16:0]  add_i = '0;
    logic [1:0]        wen_i = 2'b11;
    logic [1:0][3:0]   be_i = '0;
    logic [1:0][31:0]  wdata_i = '0;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              rerr_o;
    logic              CEN;
    logic              WEN;
    logic [3:0]        BEN;
    logic [14:0]       A;
    logic [31:0]       D;
    logic [31:0]       Q;

    int checks = 0;
    int errors = 0;

    l2_bank_port_arbiter dut (
        .CLK(CLK), .RST(RST), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .rerr_o(rerr_o), .CEN(CEN), .WEN(WEN), .BEN(BEN),
        .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // SRAM model: Q is valid the cycle after a read enable.
    logic [31:0] bank_mem [0:32767];
    always @(posedge CLK) begin
        if (!CEN) begin
            if (A >= 15'd29184) begin
                errors++;
                $display("FAIL bank_enable_oor: A=%h enabled, required CEN=1", A);
            end
            if (!WEN) begin
                for (int b = 0; b < 4; b++)
                    if (!BEN[b]) bank_mem[A][8*b +: 8] <= D[8*b +: 8];
            end else begin
                Q <= bank_mem[A];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [16:0] add0, add1;
        logic [1:0]  wen;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic [1:0]  e_gnt;
        logic        e_cen, e_wen;
        logic [3:0]  e_ben;
        logic [14:0] e_a;
        logic [31:0] e_d;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge CLK);
        RST        = v.rst;
        req_i      = v.req;
        add_i[0]   = v.add0;
        add_i[1]   = v.add1;
        wen_i      = v.wen;
        be_i[0]    = v.be0;
        be_i[1]    = v.be1;
        wdata_i[0] = v.wd0;
        wdata_i[1] = v.wd1;
        #1;
        if (v.rst || exp_q.size() == 0) begin
            exp_q.delete();
            chk("rvalid_idle", 32'(rvalid_o), 32'd0);
            chk("rerr_idle", 32'(rerr_o), 32'd0);
            chk("rdata_idle", rdata_o, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rvalid", 32'(rvalid_o), e.port ? 32'd2 : 32'd1);
            chk("rerr", 32'(rerr_o), 32'(e.err));
            chk("rdata", rdata_o, e.rdata);
        end
        chk("gnt", 32'(gnt_o), 32'(v.e_gnt));
        chk("CEN", 32'(CEN), 32'(v.e_cen));
        chk("WEN", 32'(WEN), 32'(v.e_wen));
        chk("BEN", 32'(BEN), 32'(v.e_ben));
        chk("A", 32'(A), 32'(v.e_a));
        chk("D", D, v.e_d);
        if (!v.rst && v.e_gnt != 2'b00)
            exp_q.push_back('{port: v.e_gnt[1], err: v.e_err, rdata: v.e_rdata});
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) bank_mem[i] = 32'h0;
        bank_mem[4]       = 32'h12345678;
        bank_mem[5]       = 32'h5A5A5A5A;
        bank_mem[15'h71FF] = 32'hCAFEF00D;

        //            rst  req    add0      add1      wen    be0   be1   wd0           wd1           gnt    cen   wen   ben   a         d             err   rdata
        vecs[0]  = '{1'b1, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h11110000, 32'h22220000, 2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 2'b00, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h11110000, 32'h22220000, 2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'b01, 17'h00010, 17'h00000, 2'b11, 4'hF, 4'h0, 32'h55550000, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 15'h0004, 32'h55550000, 1'b0, 32'h12345678};
        vecs[4]  = '{1'b0, 2'b10, 17'h00000, 17'h1C000, 2'b01, 4'h0, 4'h5, 32'h0,        32'hAABBCCDD, 2'b10, 1'b0, 1'b0, 4'hA, 15'h7000, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 2'b10, 17'h00000, 17'h1C000, 2'b11, 4'h0, 4'hF, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 15'h7000, 32'h0,        1'b0, 32'h00BB00DD};
        vecs[6]  = '{1'b0, 2'b11, 17'h1C7FC, 17'h00010, 2'b11, 4'hF, 4'hF, 32'h33330000, 32'h44440000, 2'b01, 1'b0, 1'b1, 4'h0, 15'h71FF, 32'h33330000, 1'b0, 32'hCAFEF00D};
        vecs[7]  = '{1'b0, 2'b11, 17'h1C7FC, 17'h00010, 2'b11, 4'hF, 4'hF, 32'h33330000, 32'h44440000, 2'b10, 1'b0, 1'b1, 4'h0, 15'h0004, 32'h44440000, 1'b0, 32'h12345678};
        vecs[8]  = '{1'b0, 2'b01, 17'h1C800, 17'h00000, 2'b11, 4'hF, 4'h0, 32'h66660000, 32'h0,        2'b01, 1'b1, 1'b1, 4'h0, 15'h7200, 32'h66660000, 1'b1, 32'hBADACCE5};
        vecs[9]  = '{1'b0, 2'b10, 17'h00000, 17'h1FFFC, 2'b01, 4'h0, 4'hF, 32'h0,        32'h11112222, 2'b10, 1'b1, 1'b0, 4'h0, 15'h7FFF, 32'h11112222, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 2'b01, 17'h00014, 17'h00000, 2'b10, 4'h0, 4'h0, 32'hDEADBEEF, 32'h0,        2'b01, 1'b0, 1'b0, 4'hF, 15'h0005, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b01, 17'h00014, 17'h00000, 2'b11, 4'hF, 4'h0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 15'h0005, 32'h0,        1'b0, 32'h5A5A5A5A};
        vecs[12] = '{1'b0, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 2'b11, 17'h00010, 17'h1C7FC, 2'b11, 4'hF, 4'h3, 32'h77770000, 32'h88880000, 2'b10, 1'b0, 1'b1, 4'hC, 15'h71FF, 32'h88880000, 1'b0, 32'hCAFEF00D};
        vecs[14] = '{1'b0, 2'b01, 17'h00010, 17'h00000, 2'b11, 4'h6, 4'h0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 4'h9, 15'h0004, 32'h0,        1'b0, 32'h12345678};
        vecs[15] = '{1'b0, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[16] = '{1'b1, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};
        vecs[17] = '{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 15'h0004, 32'h0,        1'b0, 32'h12345678};
        vecs[18] = '{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 15'h7000, 32'h0,        1'b0, 32'h00BB00DD};
        vecs[19] = '{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 15'h0004, 32'h0,        1'b0, 32'h12345678};
        vecs[20] = '{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 15'h7000, 32'h0,        1'b0, 32'h00BB00DD};
        vecs[21] = '{1'b0, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0,        1'b0, 32'h0};

        for (int i = 0; i < 22; i++) step(vecs[i]);

        // Reset landing on the response cycle of a granted read, with rr left at 1.
        step('{1'b0, 2'b01, 17'h00014, 17'h00000, 2'b11, 4'hF, 4'h0, 32'h0, 32'h0,
               2'b01, 1'b0, 1'b1, 4'h0, 15'h0005, 32'h0, 1'b0, 32'h5A5A5A5A});
        step('{1'b1, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h9, 32'hA,
               2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0, 1'b0, 32'h0});
        step('{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h9, 32'hA,
               2'b01, 1'b0, 1'b1, 4'h0, 15'h0004, 32'h9, 1'b0, 32'h12345678});
        step('{1'b0, 2'b11, 17'h00010, 17'h1C000, 2'b11, 4'hF, 4'hF, 32'h9, 32'hA,
               2'b10, 1'b0, 1'b1, 4'h0, 15'h7000, 32'hA, 1'b0, 32'h00BB00DD});
        step('{1'b0, 2'b00, 17'h00000, 17'h00000, 2'b11, 4'h0, 4'h0, 32'h0, 32'h0,
               2'b00, 1'b1, 1'b1, 4'hF, 15'h0000, 32'h0, 1'b0, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
